// File: rtl/syn_frame_gen.sv
// syn_frame_gen: byte-wide sync-framed stream transmitter.
// Each frame is one SYNC_WORD byte followed by PAYLOAD_LEN payload bytes taken
// from an upstream valid/ready source. When the source has no byte ready,
// FILL_BYTE is sent instead, so the frame period stays PAYLOAD_LEN+1 clocks.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         transmit enable; checked when idle and at the end of each frame
//   pl_data    payload byte from the source
//   pl_valid   pl_data is valid
//   pl_ready   pl_data is consumed at this edge if pl_valid is high (combinational)
//   data_out   transmitted byte (registered)
//   data_vld   data_out carries a frame byte
//   sof        high together with the SYNC_WORD byte
//   underrun   high together with each FILL_BYTE sent in place of payload
//   frame_cnt  count of completed frames, wraps at 2^FRAME_CNT_W
module syn_frame_gen #(
    parameter logic [7:0]  SYNC_WORD   = 8'hF7,
    parameter int unsigned PAYLOAD_LEN = 7,
    parameter logic [7:0]  FILL_BYTE   = 8'h00,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             pl_data,
    input  logic                   pl_valid,
    output logic                   pl_ready,
    output logic [7:0]             data_out,
    output logic                   data_vld,
    output logic                   sof,
    output logic                   underrun,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    // The state names what is sent at the next edge, not what is on data_out.
    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StPayload
    } state_t;

    localparam logic [7:0] LastIdx = 8'(PAYLOAD_LEN - 1);

    state_t     state;
    logic [7:0] idx;

    assign pl_ready = (state == StPayload);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= 8'd0;
            data_out  <= 8'h00;
            data_vld  <= 1'b0;
            sof       <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    // data_out keeps its last value while idle.
                    data_vld <= 1'b0;
                    sof      <= 1'b0;
                    underrun <= 1'b0;
                    if (en) begin
                        state <= StSync;
                    end
                end

                StSync: begin
                    data_out <= SYNC_WORD;
                    data_vld <= 1'b1;
                    sof      <= 1'b1;
                    underrun <= 1'b0;
                    idx      <= 8'd0;
                    state    <= StPayload;
                end

                StPayload: begin
                    data_vld <= 1'b1;
                    sof      <= 1'b0;
                    if (pl_valid) begin
                        data_out <= pl_data;
                        underrun <= 1'b0;
                    end else begin
                        data_out <= FILL_BYTE;
                        underrun <= 1'b1;
                    end
                    // idx advances even on underrun so the frame length is fixed.
                    if (idx == LastIdx) begin
                        idx       <= 8'd0;
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        // en only matters here: mid-frame toggles are ignored.
                        state     <= en ? StSync : StIdle;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syn_frame_gen.sv
// Bench for syn_frame_gen: directed steps from the test plan plus randomized
// payload traffic, checked every cycle against a frame-position model.
module tb_syn_frame_gen;

    localparam int L = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] data_out;
    logic       data_vld;
    logic       sof;
    logic       underrun;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Model: pos = -1 idle, 0 = sync byte next, k in 1..L = payload byte k-1 next.
    int       m_pos = -1;
    int       m_cnt = 0;
    bit [7:0] m_data = 8'h00;
    bit       m_vld = 1'b0;
    bit       m_sof = 1'b0;
    bit       m_und = 1'b0;

    bit       auto_src = 1'b1;
    bit [7:0] src = 8'h01;

    syn_frame_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .data_out  (data_out),
        .data_vld  (data_vld),
        .sof       (sof),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check pl_ready, advance model, clock DUT, compare outputs.
    task automatic tick();
        bit consumed;
        check("pl_ready", {31'd0, pl_ready}, {31'd0, (m_pos >= 1)});
        consumed = pl_valid && (m_pos >= 1);
        if (rst) begin
            m_pos = -1; m_data = 8'h00; m_vld = 0; m_sof = 0; m_und = 0; m_cnt = 0;
        end else if (m_pos < 0) begin
            m_vld = 0; m_sof = 0; m_und = 0;
            if (en) m_pos = 0;
        end else if (m_pos == 0) begin
            m_data = 8'hF7; m_vld = 1; m_sof = 1; m_und = 0; m_pos = 1;
        end else begin
            m_vld = 1; m_sof = 0;
            m_data = pl_valid ? pl_data : 8'h00;
            m_und = !pl_valid;
            if (m_pos == L) begin
                m_cnt = (m_cnt + 1) % 256;
                m_pos = en ? 0 : -1;
            end else begin
                m_pos++;
            end
        end
        @(posedge clk);
        #1;
        check("data_out", {24'd0, data_out}, {24'd0, m_data});
        check("data_vld", {31'd0, data_vld}, {31'd0, m_vld});
        check("sof", {31'd0, sof}, {31'd0, m_sof});
        check("underrun", {31'd0, underrun}, {31'd0, m_und});
        check("frame_cnt", {24'd0, frame_cnt}, m_cnt[31:0] & 32'hFF);
        if (auto_src && consumed) begin
            src++;
            pl_data = src;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        bit [7:0] exp2 [8];
        exp2 = '{8'hF7, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h04, 8'h05};

        // 1: reset, then continuous source counting from 01.
        en = 1'b0;
        do_reset(3);
        check("rst_vld", {31'd0, data_vld}, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        src = 8'h01; pl_data = src; pl_valid = 1'b1; en = 1'b1;
        tick();
        check("t1_gap", {31'd0, data_vld}, 32'd0);
        tick();
        check("t1_sync", {24'd0, data_out}, 32'hF7);
        check("t1_sof", {31'd0, sof}, 32'd1);
        for (int i = 1; i <= L; i++) begin
            tick();
            check("t1_byte", {24'd0, data_out}, 32'(i));
            check("t1_nosof", {31'd0, sof}, 32'd0);
        end
        check("t1_cnt", {24'd0, frame_cnt}, 32'd1);
        tick();
        check("t1_sync2", {24'd0, data_out}, 32'hF7);

        // 2: underrun at payload idx 2 and 3.
        en = 1'b0;
        do_reset(2);
        src = 8'h01; pl_data = src; en = 1'b1; pl_valid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            pl_valid = !(i == 3 || i == 4);
            tick();
            check("t2_byte", {24'd0, data_out}, {24'd0, exp2[i]});
            check("t2_und", {31'd0, underrun}, {31'd0, (i == 3 || i == 4)});
        end
        pl_valid = 1'b1;

        // 3: en dropped at payload idx 1 of frame 2.
        tick();
        check("t3_sync", {31'd0, sof}, 32'd1);
        tick();
        en = 1'b0;
        for (int i = 1; i < L; i++) tick();
        check("t3_last_vld", {31'd0, data_vld}, 32'd1);
        check("t3_cnt", {24'd0, frame_cnt}, 32'd2);
        tick();
        check("t3_stop", {31'd0, data_vld}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        en = 1'b1;
        tick();
        check("t3_gap", {31'd0, data_vld}, 32'd0);
        tick();
        check("t3_restart", {24'd0, data_out}, 32'hF7);

        // 4: reset asserted at payload idx 4.
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_vld", {31'd0, data_vld}, 32'd0);
        check("t4_sof", {31'd0, sof}, 32'd0);
        check("t4_data", {24'd0, data_out}, 32'h00);
        check("t4_cnt", {24'd0, frame_cnt}, 32'd0);
        check("t4_ready", {31'd0, pl_ready}, 32'd0);
        tick();
        tick();
        check("t4_sync", {24'd0, data_out}, 32'hF7);
        for (int i = 0; i < L; i++) tick();
        check("t4_cnt1", {24'd0, frame_cnt}, 32'd1);

        // 5: payload bytes equal to the sync word.
        en = 1'b0;
        do_reset(2);
        auto_src = 1'b0; pl_data = 8'hF7; pl_valid = 1'b1; en = 1'b1;
        tick();
        for (int k = 0; k < 3 * (L + 1); k++) begin
            tick();
            check("t5_data", {24'd0, data_out}, 32'hF7);
            check("t5_sof", {31'd0, sof}, {31'd0, (k % (L + 1) == 0)});
        end

        // 6: 256 back-to-back frames with random payload and underruns.
        en = 1'b0;
        do_reset(2);
        en = 1'b1;
        tick();
        for (int f = 0; f < 256; f++) begin
            for (int b = 0; b <= L; b++) begin
                pl_data = 8'($urandom);
                pl_valid = ($urandom_range(0, 3) != 0);
                tick();
                check("t6_vld", {31'd0, data_vld}, 32'd1);
            end
            if (f == 254) check("t6_cnt255", {24'd0, frame_cnt}, 32'd255);
        end
        check("t6_wrap", {24'd0, frame_cnt}, 32'd0);
        pl_valid = 1'b1;
        tick();
        check("t6_nogap", {31'd0, sof}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
